// File: rtl/regfile_pkg.sv
// Shared definitions for the vector register file and its write/read front ends.
package regfile_pkg;

  localparam int unsigned RF_NUM_REGS  = 32;
  localparam int unsigned RF_REG_WIDTH = 256;
  localparam int unsigned RF_ADDR_W    = 5;

  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_LSU = 1'b1
  } req_e;

endpackage

// File: rtl/wb_fifo.sv
// In-order {addr, data} write-back queue with a per-entry valid/address view.
module wb_fifo
  import regfile_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = RF_ADDR_W,
  parameter int unsigned DW    = RF_REG_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [AW-1:0]            push_addr,
  input  logic [DW-1:0]            push_data,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [AW-1:0]            head_addr,
  output logic [DW-1:0]            head_data,
  output logic [DEPTH-1:0]         ent_valid,
  output logic [AW-1:0]            ent_addr [DEPTH]
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push, do_pop;
  logic [PW-1:0] off;

  always_comb begin
    full      = (count_q == CW'(DEPTH));
    empty     = (count_q == '0);
    count     = count_q;
    do_push   = push && !full;
    do_pop    = pop && !empty;
    head_addr = addr_q[rd_ptr_q];
    head_data = data_q[rd_ptr_q];
    ent_addr  = addr_q;
  end

  // Entry i is live when its distance from the read pointer is below the fill count.
  always_comb begin
    ent_valid = '0;
    off       = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      off          = PW'(i) - rd_ptr_q;
      ent_valid[i] = ({1'b0, off} < count_q);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      addr_q[wr_ptr_q] <= push_addr;
      data_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/regfile_writeback_arbiter.sv
// Round-robin ALU/LSU write-back arbiter feeding the register file write port through wb_fifo.
module regfile_writeback_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned NUM_REGS  = RF_NUM_REGS,
  parameter int unsigned REG_WIDTH = RF_REG_WIDTH,
  parameter int unsigned ADDR_W    = RF_ADDR_W,
  parameter int unsigned DEPTH     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_valid,
  input  logic [ADDR_W-1:0]     alu_addr,
  input  logic [REG_WIDTH-1:0]  alu_data,
  output logic                  alu_ready,
  input  logic                  lsu_valid,
  input  logic [ADDR_W-1:0]     lsu_addr,
  input  logic [REG_WIDTH-1:0]  lsu_data,
  output logic                  lsu_ready,
  input  logic                  stall,
  output logic                  WE3,
  output logic [ADDR_W-1:0]     A3,
  output logic [REG_WIDTH-1:0]  WD3,
  output logic [NUM_REGS-1:0]   pend_mask,
  output logic                  busy
);

  logic                   full, empty;
  logic [$clog2(DEPTH):0] fill_count;
  logic                   push;
  logic [ADDR_W-1:0]      push_addr;
  logic [REG_WIDTH-1:0]   push_data;
  logic [ADDR_W-1:0]      head_addr;
  logic [REG_WIDTH-1:0]   head_data;
  logic [DEPTH-1:0]       ent_valid;
  logic [ADDR_W-1:0]      ent_addr [DEPTH];
  logic                   alu_fire, lsu_fire;
  req_e                   last_q, last_d;

  // Readies use the pre-drain full flag: a pop in the same cycle does not reopen the queue.
  always_comb begin
    alu_ready = !full && (!lsu_valid || last_q == REQ_LSU);
    lsu_ready = !full && (!alu_valid || last_q == REQ_ALU);
    alu_fire  = alu_valid && alu_ready;
    lsu_fire  = lsu_valid && lsu_ready;
    push      = alu_fire || lsu_fire;
    push_addr = alu_fire ? alu_addr : lsu_addr;
    push_data = alu_fire ? alu_data : lsu_data;
    last_d    = last_q;
    if (alu_fire)      last_d = REQ_ALU;
    else if (lsu_fire) last_d = REQ_LSU;
  end

  always_comb begin
    WE3  = !empty && !stall;
    A3   = empty ? '0 : head_addr;
    WD3  = empty ? '0 : head_data;
    busy = (fill_count != '0);
  end

  always_comb begin
    pend_mask = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (ent_valid[i]) pend_mask[ent_addr[i]] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) last_q <= REQ_LSU;
    else      last_q <= last_d;
  end

  wb_fifo #(
    .DEPTH (DEPTH),
    .AW    (ADDR_W),
    .DW    (REG_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_addr (push_addr),
    .push_data (push_data),
    .pop       (WE3),
    .full      (full),
    .empty     (empty),
    .count     (fill_count),
    .head_addr (head_addr),
    .head_data (head_data),
    .ent_valid (ent_valid),
    .ent_addr  (ent_addr)
  );

endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// Directed bench: stimulus pushes expected writes to a scoreboard, a negedge monitor checks WE3/A3/WD3.
module tb_regfile_writeback_arbiter;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         alu_valid = 1'b0, lsu_valid = 1'b0, stall = 1'b0;
  logic [4:0]   alu_addr = '0, lsu_addr = '0;
  logic [255:0] alu_data = '0, lsu_data = '0;
  logic         alu_ready, lsu_ready, WE3, busy;
  logic [4:0]   A3;
  logic [255:0] WD3;
  logic [31:0]  pend_mask;

  typedef struct packed {
    logic [4:0]   a;
    logic [255:0] d;
  } wr_t;

  wr_t sb[$];
  wr_t mon_e;
  int  total = 0;
  int  bad   = 0;
  int  ai, li;

  regfile_writeback_arbiter #(
    .NUM_REGS  (32),
    .REG_WIDTH (256),
    .ADDR_W    (5),
    .DEPTH     (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .alu_valid (alu_valid),
    .alu_addr  (alu_addr),
    .alu_data  (alu_data),
    .alu_ready (alu_ready),
    .lsu_valid (lsu_valid),
    .lsu_addr  (lsu_addr),
    .lsu_data  (lsu_data),
    .lsu_ready (lsu_ready),
    .stall     (stall),
    .WE3       (WE3),
    .A3        (A3),
    .WD3       (WD3),
    .pend_mask (pend_mask),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [255:0] dat(input logic [7:0] tagv, input logic [4:0] r);
    return {8{tagv, 8'h5A, 11'h000, r}};
  endfunction

  always @(negedge clk) begin
    if (rst && WE3) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got A3=%0d expected no write", A3);
      end else begin
        mon_e = sb.pop_front();
        chk("wb_addr", 256'(A3), 256'(mon_e.a));
        chk("wb_data", WD3, mon_e.d);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 1'b0;
    lsu_valid = 1'b0;
  endtask

  // Drive one cycle of requests; ea/el are the hand-computed readies for this cycle.
  task automatic req(input logic av, input logic [4:0] aa, input logic [255:0] ad,
                     input logic lv, input logic [4:0] la, input logic [255:0] ld,
                     input logic ea, input logic el, input string tag);
    alu_valid = av; alu_addr = aa; alu_data = ad;
    lsu_valid = lv; lsu_addr = la; lsu_data = ld;
    #1;
    chk({tag, "_alu_ready"}, 256'(alu_ready), 256'(ea));
    chk({tag, "_lsu_ready"}, 256'(lsu_ready), 256'(el));
    if (av && ea)      sb.push_back(wr_t'{a: aa, d: ad});
    else if (lv && el) sb.push_back(wr_t'{a: la, d: ld});
    tick();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_we3", 256'(WE3), 256'(0));
    chk("rst_a3", 256'(A3), 256'(0));
    chk("rst_wd3", WD3, 256'(0));
    chk("rst_pend", 256'(pend_mask), 256'(0));
    chk("rst_busy", 256'(busy), 256'(0));
    chk("rst_alu_ready", 256'(alu_ready), 256'(1));
    chk("rst_lsu_ready", 256'(lsu_ready), 256'(1));
    rst = 1'b1;
    tick();

    req(1, 5'd7, {8{32'hCAFEBABE}}, 0, 5'd0, '0, 1, 0, "t1");
    idle();
    chk("t1_we3", 256'(WE3), 256'(1));
    chk("t1_a3", 256'(A3), 256'(7));
    chk("t1_pend", 256'(pend_mask), 256'(32'h80));
    chk("t1_busy", 256'(busy), 256'(1));
    tick();
    chk("t1_pend_clear", 256'(pend_mask), 256'(0));
    chk("t1_busy_clear", 256'(busy), 256'(0));

    // Lone LSU write returns the last-grant pointer to LSU so the next tie goes to the ALU.
    req(0, 5'd0, '0, 1, 5'd20, dat(8'h20, 5'd20), 0, 1, "pre");
    idle();
    tick(); tick();

    req(1, 5'd1, dat(8'hA0, 5'd1), 1, 5'd11, dat(8'hB0, 5'd11), 1, 0, "t2a");
    req(1, 5'd2, dat(8'hA0, 5'd2), 1, 5'd11, dat(8'hB0, 5'd11), 0, 1, "t2b");
    req(1, 5'd2, dat(8'hA0, 5'd2), 1, 5'd12, dat(8'hB0, 5'd12), 1, 0, "t2c");
    req(1, 5'd3, dat(8'hA0, 5'd3), 1, 5'd12, dat(8'hB0, 5'd12), 0, 1, "t2d");
    idle();
    tick(); tick();
    chk("t2_busy", 256'(busy), 256'(0));

    stall = 1'b1;
    req(1, 5'd1, dat(8'hC0, 5'd1), 0, 5'd0, '0, 1, 0, "t3_1");
    req(1, 5'd2, dat(8'hC0, 5'd2), 0, 5'd0, '0, 1, 1, "t3_2");
    req(1, 5'd3, dat(8'hC0, 5'd3), 0, 5'd0, '0, 1, 1, "t3_3");
    req(1, 5'd4, dat(8'hC0, 5'd4), 0, 5'd0, '0, 1, 1, "t3_4");
    req(1, 5'd5, dat(8'hC0, 5'd5), 0, 5'd0, '0, 0, 0, "t3_full");
    chk("t3_busy", 256'(busy), 256'(1));
    chk("t3_pend", 256'(pend_mask), 256'(32'h1E));
    chk("t3_we3_stalled", 256'(WE3), 256'(0));
    chk("t3_a3_head", 256'(A3), 256'(1));
    idle();
    stall = 1'b0;
    repeat (4) tick();
    chk("t3_drained", 256'(busy), 256'(0));

    req(1, 5'd3, {8{32'hAAAABEEF}}, 0, 5'd0, '0, 1, 1, "t4a");
    chk("t4_pend_first", 256'(pend_mask), 256'(32'h8));
    req(0, 5'd0, '0, 1, 5'd3, {16{16'h5555}}, 0, 1, "t4b");
    chk("t4_pend_second", 256'(pend_mask), 256'(32'h8));
    chk("t4_we3", 256'(WE3), 256'(1));
    chk("t4_a3", 256'(A3), 256'(3));
    idle();
    tick();
    chk("t4_pend_clear", 256'(pend_mask), 256'(0));

    stall = 1'b1;
    req(1, 5'd16, dat(8'hD0, 5'd16), 1, 5'd24, dat(8'hE0, 5'd24), 1, 0, "t5_f1");
    req(1, 5'd17, dat(8'hD0, 5'd17), 1, 5'd24, dat(8'hE0, 5'd24), 0, 1, "t5_f2");
    req(1, 5'd17, dat(8'hD0, 5'd17), 1, 5'd25, dat(8'hE0, 5'd25), 1, 0, "t5_f3");
    req(1, 5'd18, dat(8'hD0, 5'd18), 1, 5'd25, dat(8'hE0, 5'd25), 0, 1, "t5_f4");
    stall = 1'b0;
    #1;
    chk("t5_we3_full", 256'(WE3), 256'(1));
    req(1, 5'd18, dat(8'hD0, 5'd18), 1, 5'd26, dat(8'hE0, 5'd26), 0, 0, "t5_popfull");
    ai = 2;
    li = 2;
    for (int j = 0; j < 8; j++) begin
      chk("t5_occupancy", 256'($countones(pend_mask)), 256'(3));
      if (j % 2 == 0) begin
        req(1, 5'(16 + ai), dat(8'hD0, 5'(16 + ai)), 1, 5'(24 + li), dat(8'hE0, 5'(24 + li)),
            1, 0, "t5_alu");
        ai++;
      end else begin
        req(1, 5'(16 + ai), dat(8'hD0, 5'(16 + ai)), 1, 5'(24 + li), dat(8'hE0, 5'(24 + li)),
            0, 1, "t5_lsu");
        li++;
      end
    end
    idle();
    repeat (3) tick();
    chk("t5_drained", 256'(busy), 256'(0));

    stall = 1'b1;
    req(1, 5'd5, dat(8'hF0, 5'd5), 0, 5'd0, '0, 1, 0, "t6_1");
    req(1, 5'd6, dat(8'hF0, 5'd6), 0, 5'd0, '0, 1, 1, "t6_2");
    req(1, 5'd7, dat(8'hF0, 5'd7), 0, 5'd0, '0, 1, 1, "t6_3");
    idle();
    chk("t6_pend_pre", 256'(pend_mask), 256'(32'hE0));
    #2;
    rst = 1'b0;
    #1;
    sb.delete();
    chk("t6_a3", 256'(A3), 256'(0));
    chk("t6_wd3", WD3, 256'(0));
    chk("t6_pend", 256'(pend_mask), 256'(0));
    chk("t6_busy", 256'(busy), 256'(0));
    chk("t6_alu_ready", 256'(alu_ready), 256'(1));
    chk("t6_lsu_ready", 256'(lsu_ready), 256'(1));
    #2;
    rst = 1'b1;
    tick();
    stall = 1'b0;
    repeat (5) begin
      #1;
      chk("t6_no_we3", 256'(WE3), 256'(0));
      tick();
    end

    chk("sb_empty", 256'(sb.size()), 256'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
